// File: rtl/stream_string_comparator.sv
// Streaming byte-string matcher: a 32-bit word stream passes through a
// 6-stage delay while a 5-word (20-byte) window is searched at every byte
// lane of its oldest word for a right-justified target of up to 17 bytes.
module stream_string_comparator (
  input  logic         clk,
  input  logic         n_rst,      // asynchronous, active-high despite the name
  input  logic         clear,
  input  logic [135:0] string_in,
  input  logic [4:0]   strlen,
  input  logic [31:0]  data_in,
  output logic [31:0]  data_out,
  output logic         match
);

  logic [31:0]  r_s1;
  logic [31:0]  r_s2;
  logic [31:0]  r_s3;
  logic [31:0]  r_s4;
  logic [31:0]  r_s5;
  logic [31:0]  r_data_out;
  logic         r_match;

  logic [159:0] w_window;
  logic [135:0] w_target;
  logic         w_len_ok;
  logic [3:0]   w_off_ok;
  logic         w_hit;

  // Oldest word first, so byte 0 of the window is the first byte of s4.
  assign w_window = {r_s4, r_s3, r_s2, r_s1, data_in};
  assign w_len_ok = (strlen != 5'd0) && (strlen <= 5'd17);

  // Left-justify the target so that character i always sits in byte i.
  always_comb begin
    w_target = 136'd0;
    if (w_len_ok) begin
      w_target = string_in << (8'd8 * (8'd17 - {3'd0, strlen}));
    end else begin
      w_target = 136'd0;
    end
  end

  // Compare the target at each of the four byte offsets inside s4.
  always_comb begin
    w_off_ok = {4{w_len_ok}};
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 17; i++) begin
        w_off_ok[k] = w_off_ok[k] &
                      ((5'(i) >= strlen) |
                       (w_window[159 - 8*(k+i) -: 8] == w_target[135 - 8*i -: 8]));
      end
    end
    w_hit = |w_off_ok;
  end

  // Word delay line; clear flushes every stage and drops the incoming word.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_s1       <= 32'd0;
      r_s2       <= 32'd0;
      r_s3       <= 32'd0;
      r_s4       <= 32'd0;
      r_s5       <= 32'd0;
      r_data_out <= 32'd0;
    end else if (clear) begin
      r_s1       <= 32'd0;
      r_s2       <= 32'd0;
      r_s3       <= 32'd0;
      r_s4       <= 32'd0;
      r_s5       <= 32'd0;
      r_data_out <= 32'd0;
    end else begin
      r_s1       <= data_in;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_s4       <= r_s3;
      r_s5       <= r_s4;
      r_data_out <= r_s5;
    end
  end

  // Registered match pulse, one cycle ahead of the flagged word on data_out.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_match <= 1'b0;
    end else if (clear) begin
      r_match <= 1'b0;
    end else begin
      r_match <= w_hit;
    end
  end

  assign data_out = r_data_out;
  assign match    = r_match;

endmodule

// File: tb/tb_stream_string_comparator.sv
// Self-checking bench: directed cases plus randomized traffic compared
// against a queue-based reference model of the word stream and search.
module tb_stream_string_comparator;

  logic         clk;
  logic         n_rst;
  logic         clear;
  logic [135:0] string_in;
  logic [4:0]   strlen;
  logic [31:0]  data_in;
  logic [31:0]  data_out;
  logic         match;

  int n_checks;
  int n_errors;
  int seen_pulses;

  // Reference state: every word accepted since the last flush, newest at back.
  logic [31:0] m_hist[$];
  logic [31:0] m_dout;
  logic        m_match;

  stream_string_comparator dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .string_in (string_in),
    .strlen    (strlen),
    .data_in   (data_in),
    .data_out  (data_out),
    .match     (match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Plain substring search over a 20-byte buffer, start limited to bytes 0..3.
  function automatic logic ref_hit(input logic [159:0] win, input logic [135:0] s,
                                   input logic [4:0] len);
    byte unsigned buf_b[20];
    byte unsigned tgt[$];
    bit           all_eq;
    if (len == 5'd0 || len > 5'd17) return 1'b0;
    for (int n = 0; n < 20; n++) buf_b[n] = win[159 - 8*n -: 8];
    for (int i = 0; i < int'(len); i++) tgt.push_back(s[135 - 8*(17 - int'(len) + i) -: 8]);
    for (int k = 0; k < 4; k++) begin
      all_eq = 1'b1;
      for (int i = 0; i < tgt.size(); i++)
        if (buf_b[k+i] != tgt[i]) all_eq = 1'b0;
      if (all_eq) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_flush();
    m_hist.delete();
    for (int i = 0; i < 6; i++) m_hist.push_back(32'd0);
    m_dout  = 32'd0;
    m_match = 1'b0;
  endtask

  // Apply one word for one clock, advance the model, then compare.
  task automatic drive(input logic [31:0] w, input logic clr);
    logic [159:0] win;
    int           n;
    data_in = w;
    clear   = clr;
    @(posedge clk);
    if (clr) begin
      model_flush();
    end else begin
      n       = m_hist.size();
      win     = {m_hist[n-4], m_hist[n-3], m_hist[n-2], m_hist[n-1], w};
      m_match = ref_hit(win, string_in, strlen);
      m_hist.push_back(w);
      void'(m_hist.pop_front());
      m_dout  = m_hist[0];
    end
    #1;
    if (match === 1'b1) seen_pulses++;
    check("data_out", data_out, m_dout);
    check("match", {31'd0, match}, {31'd0, m_match});
    clear = 1'b0;
  endtask

  localparam int NCASE = 7;
  logic [31:0]  case_w   [NCASE][5];
  logic [135:0] case_s   [NCASE];
  logic [4:0]   case_len [NCASE];
  int           case_clr [NCASE];
  int           case_exp [NCASE];

  initial begin
    logic [135:0] goo;
    logic [135:0] bad;
    goo = 136'("www.google.com");
    bad = 136'("www.goog1e.com");
    case_w[0] = '{32'("www."), 32'("goog"), 32'("le.c"), 32'("om  "), 32'("    ")};
    case_w[1] = '{32'(" www"), 32'(".goo"), 32'("gle."), 32'("com "), 32'("    ")};
    case_w[2] = '{32'("  ww"), 32'("w.go"), 32'("ogle"), 32'(".com"), 32'("    ")};
    case_w[3] = '{32'("   w"), 32'("ww.g"), 32'("oogl"), 32'("e.co"), 32'("m   ")};
    case_w[4] = case_w[0];
    case_w[5] = case_w[0];
    case_w[6] = case_w[0];
    case_s    = '{goo, goo, goo, goo, bad, goo, goo};
    case_len  = '{5'd14, 5'd14, 5'd14, 5'd14, 5'd14, 5'd0, 5'd14};
    case_clr  = '{-1, -1, -1, -1, -1, -1, 3};
    case_exp  = '{1, 1, 1, 1, 0, 0, 0};
  end

  initial begin
    logic [31:0] w;
    n_checks    = 0;
    n_errors    = 0;
    seen_pulses = 0;
    clear       = 1'b0;
    data_in     = 32'd0;
    string_in   = 136'("www.google.com");
    strlen      = 5'd14;
    n_rst       = 1'b1;
    #1;
    check("reset_dout", data_out, 32'd0);
    check("reset_match", {31'd0, match}, 32'd0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b0;
    model_flush();
    drive(32'd0, 1'b1);

    // Directed cases from the stream plan.
    for (int c = 0; c < NCASE; c++) begin
      string_in = case_s[c];
      strlen    = case_len[c];
      drive(32'h0101_0101, 1'b1);   // flush to a non-matching state
      seen_pulses = 0;
      for (int i = 0; i < 5; i++) begin
        if (case_clr[c] == i) drive(32'("XXXX"), 1'b1);
        drive(case_w[c][i], 1'b0);
      end
      repeat (7) drive(32'd0, 1'b0);
      check($sformatf("pulses_case%0d", c), seen_pulses, case_exp[c]);
    end

    // Randomized traffic over a tiny alphabet so short targets hit often.
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 40 == 0) begin
        string_in = 136'd0;
        for (int j = 0; j < 17; j++) string_in[8*j +: 8] = ($urandom_range(0, 1) != 0) ? 8'h61 : 8'h62;
        case ($urandom_range(0, 9))
          0:       strlen = 5'd0;
          1:       strlen = 5'($urandom_range(18, 31));
          2:       strlen = 5'($urandom_range(6, 17));
          default: strlen = 5'($urandom_range(1, 5));
        endcase
      end
      for (int j = 0; j < 4; j++) w[8*j +: 8] = ($urandom_range(0, 1) != 0) ? 8'h61 : 8'h62;
      drive(w, ($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset mid-stream drops everything at once.
    string_in = 136'("ab");
    strlen    = 5'd2;
    for (int i = 0; i < 4; i++) drive(32'("abab"), 1'b0);
    #2 n_rst = 1'b1;
    #1;
    check("midreset_dout", data_out, 32'd0);
    check("midreset_match", {31'd0, match}, 32'd0);
    @(posedge clk);
    #1 n_rst = 1'b0;
    model_flush();
    repeat (8) drive(32'h1234_5678, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
